// File: rtl/debug_probe_scanner_if.sv
// Bundles the scanner's host-facing and core-facing signals.
// Latency: none, wires only.
// Backpressure: none. start is a bare pulse; busy/done report progress.
//
// Port summary:
//   start, mode            host request (mode: 0 = SRAM, 1 = register file)
//   busy, done             scan progress back to the host
//   probe_sel              drives the core's SW select lines
//   pc_probe, data_probe   core GPIO_0 / GPIO_1 probe buses
//   tx                     UART 8N1 serial output, idle high
// Modports: slave = scanner side, master = host/core side.
interface debug_probe_scanner_if;
  logic        start;
  logic        mode;
  logic [9:0]  probe_sel;
  logic [31:0] pc_probe;
  logic [31:0] data_probe;
  logic        tx;
  logic        busy;
  logic        done;

  modport slave (
    input  start, mode, pc_probe, data_probe,
    output probe_sel, tx, busy, done
  );

  modport master (
    output start, mode, pc_probe, data_probe,
    input  probe_sel, tx, busy, done
  );
endinterface

// File: rtl/debug_probe_scanner.sv
// Walks every core debug probe address, snapshots PC plus NUM_ENTRIES words, streams the frame over UART 8N1.
// Latency: NUM_ENTRIES*(SETTLE_CYCLES+1) cycles of scanning, then (10*CLKS_PER_BIT+1) cycles per frame byte.
// Backpressure: none. start is honoured only while idle; busy stays high from accepted start until done.
//
// Ports: clk, reset (async, active high) plus the slave side of debug_probe_scanner_if
// (start/mode in, probe_sel out, pc_probe/data_probe in, tx/busy/done out).
// Frame: A5, mode, pc_snap (4 bytes MSB first), each buffered word (4 bytes MSB first).
// Optional macro PROBE_SCAN_CHECKSUM_EN appends the XOR of every byte after the header.
module debug_probe_scanner #(
  parameter int SETTLE_CYCLES = 32,
  parameter int CLKS_PER_BIT  = 434,
  parameter int NUM_ENTRIES   = 32
) (
  input logic                  clk,
  input logic                  reset,
  debug_probe_scanner_if.slave bus
);

  localparam int IDX_W    = $clog2(NUM_ENTRIES);
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int BIT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [BIT_W-1:0]    BIT_LAST    = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(NUM_ENTRIES - 1);

`ifdef PROBE_SCAN_CHECKSUM_EN
  localparam logic [7:0] LAST_PTR = 8'(6 + 4 * NUM_ENTRIES);
`else
  localparam logic [7:0] LAST_PTR = 8'(5 + 4 * NUM_ENTRIES);
`endif

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETTLE  = 3'd1;
  localparam logic [2:0] SAMPLE  = 3'd2;
  localparam logic [2:0] TX_LOAD = 3'd3;
  localparam logic [2:0] TX_BIT  = 3'd4;
  localparam logic [2:0] FINISH  = 3'd5;

  logic [2:0]          state;
  logic [IDX_W-1:0]    index;
  logic [SETTLE_W-1:0] settleCnt;
  logic [BIT_W-1:0]    bitTimer;
  logic [3:0]          bitCnt;
  logic [7:0]          bytePtr;
  logic [9:0]          shiftReg;
  logic                modeLat;
  logic [31:0]         pcSnap;
  logic [9:0]          probeSel;
  logic [31:0]         snapBuf [NUM_ENTRIES];
`ifdef PROBE_SCAN_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  // SW layout seen by the core: bit 9 selects the probe source, low bits the address.
  function automatic logic [9:0] selFor(input logic m, input logic [IDX_W-1:0] idx);
    selFor = {m, 9'd0} | 10'(idx);
  endfunction

  function automatic logic [7:0] pickByte(input logic [31:0] w, input logic [1:0] s);
    case (s)
      2'd0:    pickByte = w[31:24];
      2'd1:    pickByte = w[23:16];
      2'd2:    pickByte = w[15:8];
      default: pickByte = w[7:0];
    endcase
  endfunction

  // Frame byte at bytePtr. PC starts at offset 2 and words at offset 6, so in both
  // regions the MSB-first byte lane is the low two pointer bits minus 2.
  logic [7:0]       frameByte;
  logic [1:0]       byteSel;
  logic [IDX_W-1:0] wordIdx;

  always_comb begin
    byteSel   = bytePtr[1:0] - 2'd2;
    wordIdx   = IDX_W'((bytePtr - 8'd6) >> 2);
    frameByte = 8'h00;
    if (bytePtr == 8'd0) begin
      frameByte = 8'hA5;
    end else if (bytePtr == 8'd1) begin
      frameByte = {7'd0, modeLat};
    end else if (bytePtr < 8'd6) begin
      frameByte = pickByte(pcSnap, byteSel);
`ifdef PROBE_SCAN_CHECKSUM_EN
    end else if (bytePtr == LAST_PTR) begin
      frameByte = csum;
`endif
    end else begin
      frameByte = pickByte(snapBuf[wordIdx], byteSel);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      index     <= '0;
      settleCnt <= '0;
      bitTimer  <= '0;
      bitCnt    <= '0;
      bytePtr   <= '0;
      shiftReg  <= '1;
      modeLat   <= 1'b0;
      pcSnap    <= '0;
      probeSel  <= '0;
`ifdef PROBE_SCAN_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            modeLat   <= bus.mode;
            index     <= '0;
            settleCnt <= '0;
            probeSel  <= selFor(bus.mode, '0);
            state     <= SETTLE;
          end
        end

        // Wait out at least one core slow-clock period so the probe bus reflects probeSel.
        SETTLE: begin
          if (settleCnt == SETTLE_LAST) begin
            settleCnt <= '0;
            state     <= SAMPLE;
          end else begin
            settleCnt <= settleCnt + 1'b1;
          end
        end

        SAMPLE: begin
          if (index == '0) begin
            pcSnap <= bus.pc_probe;
          end
          if (index == LAST_IDX) begin
            bytePtr <= '0;
`ifdef PROBE_SCAN_CHECKSUM_EN
            csum    <= '0;
`endif
            state   <= TX_LOAD;
          end else begin
            index    <= index + 1'b1;
            probeSel <= selFor(modeLat, index + 1'b1);
            state    <= SETTLE;
          end
        end

        // One idle-high cycle between bytes while the next byte is framed.
        TX_LOAD: begin
          shiftReg <= {1'b1, frameByte, 1'b0};
          bitTimer <= '0;
          bitCnt   <= '0;
`ifdef PROBE_SCAN_CHECKSUM_EN
          // Header excluded; the checksum byte folding into itself is harmless, nothing follows it.
          if (bytePtr != 8'd0) begin
            csum <= csum ^ frameByte;
          end
`endif
          state    <= TX_BIT;
        end

        TX_BIT: begin
          if (bitTimer == BIT_LAST) begin
            bitTimer <= '0;
            if (bitCnt == 4'd9) begin
              if (bytePtr == LAST_PTR) begin
                probeSel <= '0;
                state    <= FINISH;
              end else begin
                bytePtr <= bytePtr + 8'd1;
                state   <= TX_LOAD;
              end
            end else begin
              bitCnt   <= bitCnt + 4'd1;
              shiftReg <= {1'b1, shiftReg[9:1]};
            end
          end else begin
            bitTimer <= bitTimer + 1'b1;
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Snapshot storage carries no reset; only words written during the current scan are sent.
  always_ff @(posedge clk) begin
    if (state == SAMPLE) begin
      snapBuf[index] <= bus.data_probe;
    end
  end

  // Outputs decode straight from state so an asynchronous reset forces them at once.
  assign bus.tx        = (state == TX_BIT) ? shiftReg[0] : 1'b1;
  assign bus.busy      = (state != IDLE) && (state != FINISH);
  assign bus.done      = (state == FINISH);
  assign bus.probe_sel = probeSel;

endmodule

// File: tb/tb_debug_probe_scanner.sv
// Directed bench for debug_probe_scanner: stimulus table of probe patterns plus hand sequences
// for UART bit timing, start while busy, start during FINISH and reset in the middle of a byte.
// Handles both builds (with and without PROBE_SCAN_CHECKSUM_EN).
module tb_debug_probe_scanner;

  localparam int CPB    = 4;
  localparam int SETTLE = 4;
  localparam int N      = 32;
  localparam int BUDGET = 8000;
`ifdef PROBE_SCAN_CHECKSUM_EN
  localparam int FRAME_LEN = 135;
  localparam bit HAS_CSUM  = 1'b1;
`else
  localparam int FRAME_LEN = 134;
  localparam bit HAS_CSUM  = 1'b0;
`endif

  typedef struct {
    logic        mode;
    logic [31:0] pc;
    logic [31:0] base;
    logic [31:0] inc;
    logic        lastChk;
    logic [7:0]  lastByte;
  } vec_t;

  vec_t vecs [4];

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  debug_probe_scanner_if busIf ();

  debug_probe_scanner #(
    .SETTLE_CYCLES(SETTLE),
    .CLKS_PER_BIT (CPB),
    .NUM_ENTRIES  (N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (busIf)
  );

  // Core probe model: the probe buses follow the select lines.
  logic [31:0] curPc, curBase, curInc;
  assign busIf.pc_probe   = curPc;
  assign busIf.data_probe = curBase + curInc * 32'(busIf.probe_sel[4:0]);

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // UART receiver: start detected on the first low sample, bits sampled mid-cell.
  logic [7:0] rxQ [$];
  logic [7:0] rxSh;
  int         rxCnt = 0;
  bit         rxActive = 1'b0;
  int         frameErr = 0;

  always @(negedge clk) begin
    if (reset) begin
      rxActive = 1'b0;
    end else if (!rxActive) begin
      if (busIf.tx === 1'b0) begin
        rxActive = 1'b1;
        rxCnt    = 0;
      end
    end else begin
      rxCnt++;
      if (rxCnt == 2) begin
        if (busIf.tx !== 1'b0) frameErr++;
      end else if (rxCnt >= 6 && rxCnt <= 34 && (rxCnt % 4) == 2) begin
        rxSh = {busIf.tx, rxSh[7:1]};
      end else if (rxCnt == 38) begin
        if (busIf.tx !== 1'b1) frameErr++;
        rxQ.push_back(rxSh);
        rxActive = 1'b0;
      end
    end
  end

  // Select-line and done monitor.
  logic [9:0] selLog [$];
  int         holdLog [$];
  int         holdCnt = 0;
  logic [9:0] lastSel = '0;
  bit         prevBusy = 1'b0;
  int         doneCnt = 0;

  always @(negedge clk) begin
    if (busIf.done === 1'b1) doneCnt++;
    if (busIf.busy === 1'b1 && (!prevBusy || busIf.probe_sel !== lastSel)) begin
      selLog.push_back(busIf.probe_sel);
      holdLog.push_back(holdCnt);
      holdCnt = 1;
    end else begin
      holdCnt++;
    end
    lastSel  = busIf.probe_sel;
    prevBusy = (busIf.busy === 1'b1);
  end

  function automatic logic [7:0] expByte(input int v, input int i);
    logic [31:0] w;
    logic [7:0]  x;
    if (i == 0) return 8'hA5;
    if (i == 1) return {7'd0, vecs[v].mode};
    if (i < 6) return 8'(vecs[v].pc >> (8 * (5 - i)));
    if (i < 6 + 4 * N) begin
      w = vecs[v].base + vecs[v].inc * 32'((i - 6) / 4);
      return 8'(w >> (8 * (3 - ((i - 6) % 4))));
    end
    x = 8'h00;
    for (int k = 1; k < 6 + 4 * N; k++) x ^= expByte(v, k);
    return x;
  endfunction

  task automatic setVec(input int v);
    busIf.mode = vecs[v].mode;
    curPc      = vecs[v].pc;
    curBase    = vecs[v].base;
    curInc     = vecs[v].inc;
  endtask

  task automatic pulseStart();
    @(negedge clk);
    busIf.start = 1'b1;
    @(negedge clk);
    busIf.start = 1'b0;
  endtask

  // Full scan + frame check. restartAt >= 0 re-pulses start when that index is on the bus;
  // startAtFinish pulses start during the done cycle.
  task automatic runScan(input int v, input int restartAt, input bit startAtFinish);
    int cyc;
    int busyDrops;
    int badHold;
    int len;
    bit restarted;
    setVec(v);
    rxQ.delete();
    selLog.delete();
    holdLog.delete();
    doneCnt   = 0;
    frameErr  = 0;
    cyc       = 0;
    busyDrops = 0;
    restarted = 1'b0;
    pulseStart();
    while (busIf.done !== 1'b1 && cyc < BUDGET) begin
      if (busIf.busy !== 1'b1) busyDrops++;
      busIf.start = (restartAt >= 0) && !restarted && (busIf.probe_sel[4:0] == 5'(restartAt));
      if (busIf.start) restarted = 1'b1;
      @(negedge clk);
      cyc++;
    end
    busIf.start = 1'b0;
    check($sformatf("v%0d done_seen", v), 32'(cyc < BUDGET), 1);
    check($sformatf("v%0d busy_held", v), busyDrops, 0);
    if (startAtFinish) begin
      busIf.start = 1'b1;
      @(negedge clk);
      busIf.start = 1'b0;
      check($sformatf("v%0d start_in_finish_ignored", v), 32'(busIf.busy), 0);
    end
    repeat (4) @(negedge clk);
    check($sformatf("v%0d done_count", v), doneCnt, 1);
    check($sformatf("v%0d frame_err", v), frameErr, 0);
    check($sformatf("v%0d frame_len", v), rxQ.size(), FRAME_LEN);
    len = (rxQ.size() < FRAME_LEN) ? rxQ.size() : FRAME_LEN;
    for (int i = 0; i < len; i++)
      check($sformatf("v%0d byte%0d", v, i), rxQ[i], expByte(v, i));
    if (vecs[v].lastChk && rxQ.size() > 0)
      check($sformatf("v%0d last_byte", v), rxQ[rxQ.size() - 1], vecs[v].lastByte);
    check($sformatf("v%0d sel_count", v), selLog.size(), N);
    len = (selLog.size() < N) ? selLog.size() : N;
    for (int i = 0; i < len; i++)
      check($sformatf("v%0d sel%0d", v, i), selLog[i], {vecs[v].mode, 9'd0} | 10'(i));
    badHold = 0;
    for (int i = 1; i < selLog.size(); i++)
      if (holdLog[i] != SETTLE + 1) badHold++;
    check($sformatf("v%0d sel_hold", v), badHold, 0);
  endtask

  initial begin
    int lv [10];
    int cyc;
    int bad;
    bit found;

    lv = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    vecs[0] = '{mode: 1'b1, pc: 32'h0000_0040, base: 32'h1000_0000, inc: 32'd1,
                lastChk: 1'b1, lastByte: (HAS_CSUM ? 8'h41 : 8'h1F)};
    vecs[1] = '{mode: 1'b0, pc: 32'h0000_0000, base: 32'hFFFF_FFFF, inc: 32'd0,
                lastChk: 1'b1, lastByte: (HAS_CSUM ? 8'h00 : 8'hFF)};
    vecs[2] = '{mode: 1'b1, pc: 32'hDEAD_BEEF, base: 32'h0123_4567, inc: 32'h0101_0101,
                lastChk: !HAS_CSUM, lastByte: 8'h86};
    vecs[3] = '{mode: 1'b0, pc: 32'h8000_0001, base: 32'hA5A5_0000, inc: 32'h0000_0011,
                lastChk: !HAS_CSUM, lastByte: 8'h0F};

    reset       = 1'b1;
    busIf.start = 1'b0;
    busIf.mode  = 1'b0;
    curPc       = '0;
    curBase     = '0;
    curInc      = '0;
    repeat (3) @(negedge clk);
    check("rst probe_sel", 32'(busIf.probe_sel), 0);
    check("rst tx", 32'(busIf.tx), 1);
    check("rst busy", 32'(busIf.busy), 0);
    check("rst done", 32'(busIf.done), 0);
    reset = 1'b0;

    // UART bit timing of the header byte and the one-cycle gap before byte 1.
    setVec(0);
    pulseStart();
    cyc = 0;
    while (busIf.tx !== 1'b0 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    check("hdr start_seen", 32'(cyc < BUDGET), 1);
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int j = 0; j < CPB; j++) begin
        if (busIf.tx !== 1'(lv[k])) bad++;
        @(negedge clk);
      end
      check($sformatf("hdr bit%0d", k), bad, 0);
    end
    check("load gap idle", 32'(busIf.tx), 1);
    @(negedge clk);
    check("byte1 start bit", 32'(busIf.tx), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Table of probe patterns; vector 1 also pulses start during the done cycle.
    for (int v = 0; v < 4; v++) runScan(v, -1, v == 1);

    // Second start while scanning index 10 must not restart the walk.
    runScan(0, 10, 1'b0);

    // Reset during data bit 3 of byte 20.
    setVec(2);
    rxQ.delete();
    pulseStart();
    cyc   = 0;
    found = 1'b0;
    while (!found && cyc < BUDGET) begin
      @(negedge clk);
      #1;
      cyc++;
      found = rxActive && (rxQ.size() == 20) && (rxCnt == 17);
    end
    check("mid reset reached", 32'(found), 1);
    reset = 1'b1;
    #1;
    check("mid reset tx", 32'(busIf.tx), 1);
    check("mid reset busy", 32'(busIf.busy), 0);
    check("mid reset probe_sel", 32'(busIf.probe_sel), 0);
    check("mid reset done", 32'(busIf.done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    runScan(3, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
